fetch_mem_resp: RTL and testbench
=================================

Name: fetch_mem_resp

Overview:
- Memory-side responder for the fetch stage's instruction-read interface.
- Accepts single-word read or write requests, completes each after a fixed, parameterised latency, and reports progress with `stall` and `done`.
- Replaces the zero-latency instruction memory so fetch/stall logic can be exercised against realistic memory timing.
- Writes are used for program load by the bench/loader.

Parameters:
- N, 16, data and address width in bits.
- ADDR_W, 8, word-index width; array depth = 2**ADDR_W words.
- LAT, 3, request-to-done latency in cycles; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- rd  input  1  read request.
- wr  input  1  write request.
- addr  input  N  byte address; word index = addr[ADDR_W:1]; addr[0] must be 0.
- data_in  input  N  write data.
- data_out  output  N  read data; valid while done=1, held until the next done.
- done  output  1  one-cycle completion pulse.
- stall  output  1  request in progress, not yet complete.
- err  output  1  error flag; see rules below.

Behaviour:
- Reset (rst=0 at posedge):
  - Next cycle: state=IDLE, done=0, stall=0, err=0, data_out=0, counter=0.
  - Memory array is not cleared.
  - Reset mid-operation aborts the transaction. No done is produced for it, and a pending write is discarded.
- States are IDLE, WAIT and RESP. All outputs are registered or decoded from state only (no combinational path from the inputs).
- Acceptance:
  - A request is accepted at a posedge where state is IDLE or RESP and exactly one of rd/wr is 1.
  - The bus is latched at acceptance: op, addr, data_in.
  - If LAT=1, go to RESP. Otherwise go to WAIT with the counter loaded with LAT-1.
- WAIT:
  - stall=1.
  - The counter decrements each cycle. When it reaches 1, the next state is RESP.
  - rd/wr are ignored in WAIT (no queueing). The initiator must re-present the request after done.
- RESP (exactly one cycle):
  - done=1, stall=0.
  - Read: data_out = mem[latched index].
  - Write: mem[latched index] is updated at the edge entering RESP, and data_out holds its previous value.
  - Without a new request, next state is IDLE. With a new request, it is accepted and the transaction restarts (back-to-back throughput of one per LAT cycles).
- Timing: for a request accepted at edge T, stall=1 during cycles T+1..T+LAT-1 and done=1 during cycle T+LAT.
- Read-after-write ordering: a read accepted in a write's RESP cycle returns the new data.
- Conflicting request (rd=1 and wr=1 where a request would be accepted):
  - Not accepted; state goes to or remains IDLE.
  - err=1 for exactly the next cycle, with done=0.
- Misaligned request (addr[0]=1):
  - Accepted and timed normally.
  - In RESP: done=1, err=1, data_out=0.
  - A misaligned write is suppressed (memory unchanged).
- Address bits above ADDR_W are ignored, so addresses wrap modulo 2**(ADDR_W+1) bytes.
- err=0 in all other cycles.
- The counter width is 4 bits.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with rd=1 -> done=0, stall=0, err=0, data_out=0x0000; no request is accepted.
2. Write then read, LAT=3:
   - Write 0xBEEF to 0x0010 -> stall=1 at T+1 and T+2, done=1 at T+3.
   - Then read 0x0010 -> done=1 at T'+3 with data_out=0xBEEF.
3. Back-to-back:
   - Write 0x1234 to 0x0002 and 0x5678 to 0x0004.
   - Read 0x0002; present a read of 0x0004 during its done cycle.
   - Result: done pulses 3 cycles apart, with data_out 0x1234 then 0x5678.
   - A rd pulse during WAIT produces no extra done.
4. Conflict: rd=wr=1 from IDLE -> err=1 for one cycle, done=0, stall=0; the next legal read completes normally.
5. Misaligned:
   - Read 0x0011 -> done=1, err=1, data_out=0x0000 at T+3.
   - Write 0xFFFF to 0x0011, then read 0x0010 -> returns the prior 0xBEEF.
6. Reset mid-operation:
   - Accept a write of 0xAAAA to 0x0020 (pre-loaded 0x1111), then drive rst=0 at T+1.
   - Result: no done; all outputs 0 the next cycle.
   - A read of 0x0020 returns 0x1111.

Source files
------------

// File: rtl/fetch_mem_resp.sv
// Fixed-latency single-word memory responder for the fetch stage.
// Each request is latched on acceptance and completes LAT cycles later with a one-cycle done.
module fetch_mem_resp #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int LAT    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd,
  input  logic         wr,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         done,
  output logic         stall,
  output logic         err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              err_q;

  logic              op_wr_p0;
  logic              mis_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic [N-1:0]      wdata_p0;

  logic [N-1:0]      mem [0:(1<<ADDR_W)-1];

  logic              can_accept;
  logic              accept;
  logic              conflict;
  logic              enter_resp;
  logic              rsp_wr;
  logic              rsp_mis;
  logic [ADDR_W-1:0] rsp_idx;
  logic [N-1:0]      rsp_wdata;

  // Byte-address bits above the word index are deliberately ignored (address wrap).
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[N-1:ADDR_W+1];

  always_comb begin
    can_accept = (state == S_IDLE) || (state == S_RESP);
    accept     = can_accept && (rd ^ wr);
    conflict   = can_accept && rd && wr;
    enter_resp = ((state == S_WAIT) && (cnt == 4'd1)) || (accept && (LAT == 1));
    // With LAT=1 the response is produced straight from the bus at acceptance.
    if (LAT == 1) begin
      rsp_wr    = wr;
      rsp_mis   = addr[0];
      rsp_idx   = addr[ADDR_W:1];
      rsp_wdata = data_in;
    end else begin
      rsp_wr    = op_wr_p0;
      rsp_mis   = mis_p0;
      rsp_idx   = idx_p0;
      rsp_wdata = wdata_p0;
    end
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_p0 <= wr;
      mis_p0   <= addr[0];
      idx_p0   <= addr[ADDR_W:1];
      wdata_p0 <= data_in;
    end
  end

  // Stage p1: control sequencing and response register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      err_q    <= 1'b0;
      data_out <= '0;
    end else begin
      err_q <= conflict || (enter_resp && rsp_mis);
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (LAT == 1) begin
              state <= S_RESP;
              cnt   <= 4'd0;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
      if (enter_resp) begin
        if (rsp_mis) begin
          data_out <= '0;
        end else if (!rsp_wr) begin
          data_out <= mem[rsp_idx];
        end
      end
    end
  end

  // Array update lands on the edge entering RESP; a reset on that edge discards it.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && rsp_wr && !rsp_mis) begin
      mem[rsp_idx] <= rsp_wdata;
    end
  end

  assign done  = (state == S_RESP);
  assign stall = (state == S_WAIT);
  assign err   = err_q;

endmodule

// File: tb/tb_fetch_mem_resp.sv
// Directed bench for fetch_mem_resp at LAT=3 with hand-computed expectations.
module tb_fetch_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  fetch_mem_resp #(.N(16), .ADDR_W(8), .LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .stall    (stall),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Present one request, check the stall window, end inside the done cycle.
  task automatic txn(input string tag, input bit w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_q,
                     input bit exp_err, input bit poke);
    rd = !w; wr = w; addr = a; data_in = d;
    tick();
    idle_bus();
    chk({tag, "/stall1"}, 16'(stall), 16'd1);
    chk({tag, "/done1"}, 16'(done), 16'd0);
    if (poke) begin
      rd = 1'b1; addr = 16'h0010;
    end
    tick();
    idle_bus();
    chk({tag, "/stall2"}, 16'(stall), 16'd1);
    chk({tag, "/done2"}, 16'(done), 16'd0);
    tick();
    chk({tag, "/done"}, 16'(done), 16'd1);
    chk({tag, "/stall3"}, 16'(stall), 16'd0);
    chk({tag, "/err"}, 16'(err), 16'(exp_err));
    chk({tag, "/data"}, data_out, exp_q);
  endtask

  initial begin
    rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 16'h0010; data_in = 16'h0000;

    // 1: reset held two cycles with rd asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst/done", 16'(done), 16'd0);
      chk("rst/stall", 16'(stall), 16'd0);
      chk("rst/err", 16'(err), 16'd0);
      chk("rst/data", data_out, 16'h0000);
    end
    rst = 1'b1; idle_bus();
    tick();
    chk("rst/noacc", 16'(stall), 16'd0);

    // 2: write then read
    txn("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("wr_beef/idle", 16'(done), 16'd0);
    txn("rd_beef", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    tick();

    // 3: back-to-back reads, stray rd during WAIT
    txn("wr_1234", 1'b1, 16'h0002, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
    txn("wr_5678", 1'b1, 16'h0004, 16'h5678, 16'hBEEF, 1'b0, 1'b0);
    txn("b2b_a", 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 1'b1);
    txn("b2b_b", 1'b0, 16'h0004, 16'h0000, 16'h5678, 1'b0, 1'b0);
    tick();
    chk("b2b/nodone1", 16'(done), 16'd0);
    chk("b2b/nostall", 16'(stall), 16'd0);
    tick();
    chk("b2b/nodone2", 16'(done), 16'd0);

    // 4: conflicting request
    rd = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'h9999;
    tick();
    idle_bus();
    chk("conf/err", 16'(err), 16'd1);
    chk("conf/done", 16'(done), 16'd0);
    chk("conf/stall", 16'(stall), 16'd0);
    tick();
    chk("conf/err_clr", 16'(err), 16'd0);
    chk("conf/hold", data_out, 16'h5678);
    txn("conf/next", 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 1'b0);
    tick();

    // 5: misaligned accesses and address wrap
    txn("mis_rd", 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("mis_rd/err_clr", 16'(err), 16'd0);
    txn("mis_wr", 1'b1, 16'h0011, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    tick();
    txn("mis_chk", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    tick();
    txn("wrap", 1'b0, 16'h0210, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    tick();

    // read accepted in a write's done cycle sees the new data
    txn("raw_wr", 1'b1, 16'h0030, 16'h4321, 16'hBEEF, 1'b0, 1'b0);
    txn("raw_rd", 1'b0, 16'h0030, 16'h0000, 16'h4321, 1'b0, 1'b0);
    tick();

    // 6: reset during a write
    txn("pre_1111", 1'b1, 16'h0020, 16'h1111, 16'h4321, 1'b0, 1'b0);
    tick();
    rd = 1'b0; wr = 1'b1; addr = 16'h0020; data_in = 16'hAAAA;
    tick();
    idle_bus();
    chk("abort/stall", 16'(stall), 16'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort/done", 16'(done), 16'd0);
    chk("abort/stall0", 16'(stall), 16'd0);
    chk("abort/err", 16'(err), 16'd0);
    chk("abort/data", data_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort/nodone", 16'(done), 16'd0);
    end
    txn("abort/rd", 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
